// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU,
//            raising a pipeline stall request while a divide is in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            abort,
    output logic            stall_req,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [1:0]       C_S_IDLE  = 2'd0;
    localparam logic [1:0]       C_S_BUSY  = 2'd1;
    localparam logic [1:0]       C_S_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] C_STEPS   = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(1);
    localparam logic [XLEN-1:0]  C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q,        state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [XLEN-1:0] dvd_q,          dvd_d;
    logic [XLEN-1:0] rem_q,          rem_d;
    logic [XLEN-1:0] dsr_q,          dsr_d;
    logic            is_rem_q,       is_rem_d;
    logic            neg_quo_q,      neg_quo_d;
    logic            neg_rem_q,      neg_rem_d;
    logic [XLEN-1:0] result_q,       result_d;
    logic            result_valid_q, result_valid_d;

    logic            w_is_signed;
    logic            w_is_rem;
    logic            w_rs1_neg;
    logic            w_rs2_neg;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_issue;
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_step;
    logic [XLEN-1:0] w_quo_step;
    logic [XLEN-1:0] w_final;

    // Operand decode and special-case detection, used only on the issue cycle
    assign w_is_signed   = ~funct3[0];
    assign w_is_rem      = funct3[1];
    assign w_rs1_neg     = w_is_signed & rs1_data[XLEN-1];
    assign w_rs2_neg     = w_is_signed & rs2_data[XLEN-1];
    assign w_abs1        = w_rs1_neg ? -rs1_data : rs1_data;
    assign w_abs2        = w_rs2_neg ? -rs2_data : rs2_data;
    assign w_div0        = (rs2_data == '0);
    assign w_ovf         = w_is_signed & (rs1_data == C_INT_MIN) & (rs2_data == '1);
    assign w_special     = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? (w_is_rem ? rs1_data : '1)
                                  : (w_is_rem ? '0 : C_INT_MIN);
    assign w_issue       = (state_q == C_S_IDLE) & start & ~abort;

    // One restoring step; the extra bit keeps unsigned divisors >= 2^31 exact
    assign w_rem_shift = {rem_q, dvd_q[XLEN-1]};
    assign w_diff      = w_rem_shift - {1'b0, dsr_q};
    assign w_ge        = ~w_diff[XLEN];
    assign w_rem_step  = w_ge ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
    assign w_quo_step  = {dvd_q[XLEN-2:0], w_ge};
    assign w_final     = is_rem_q ? (neg_rem_q ? -w_rem_step : w_rem_step)
                                  : (neg_quo_q ? -w_quo_step : w_quo_step);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= C_S_IDLE;
            cnt_q          <= '0;
            dvd_q          <= '0;
            rem_q          <= '0;
            dsr_q          <= '0;
            is_rem_q       <= 1'b0;
            neg_quo_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dvd_q          <= dvd_d;
            rem_q          <= rem_d;
            dsr_q          <= dsr_d;
            is_rem_q       <= is_rem_d;
            neg_quo_q      <= neg_quo_d;
            neg_rem_q      <= neg_rem_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = C_S_IDLE;
        end else begin
            case (state_q)
                C_S_IDLE: if (start)          state_d = w_special ? C_S_DONE : C_S_BUSY;
                C_S_BUSY: if (cnt_q == C_LAST) state_d = C_S_DONE;
                C_S_DONE:                     state_d = C_S_IDLE;
                default:                      state_d = C_S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d          = cnt_q;
        dvd_d          = dvd_q;
        rem_d          = rem_q;
        dsr_d          = dsr_q;
        is_rem_d       = is_rem_q;
        neg_quo_d      = neg_quo_q;
        neg_rem_d      = neg_rem_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        if (w_issue) begin
            dvd_d     = w_abs1;
            dsr_d     = w_abs2;
            rem_d     = '0;
            cnt_d     = C_STEPS;
            is_rem_d  = w_is_rem;
            neg_quo_d = w_rs1_neg ^ w_rs2_neg;
            neg_rem_d = w_rs1_neg;
            if (w_special) begin
                result_d       = w_special_res;
                result_valid_d = 1'b1;
            end
        end else if ((state_q == C_S_BUSY) && !abort) begin
            dvd_d = w_quo_step;
            rem_d = w_rem_step;
            cnt_d = cnt_q - C_LAST;
            // Sign fix lands on the final step so DONE only has to present it
            if (cnt_q == C_LAST) begin
                result_d       = w_final;
                result_valid_d = 1'b1;
            end
        end
    end

    assign stall_req    = w_issue | ((state_q == C_S_BUSY) & ~abort);
    assign busy         = (state_q != C_S_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Brief    : Scoreboard bench for div_unit with directed and random divides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  funct3 = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        stall_req;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    div_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .funct3       (funct3),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .abort        (abort),
        .stall_req    (stall_req),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f3)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every result_valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && result_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: result %h at cycle %0d, none expected", result, cyc);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("valid_cycle", cyc, e.due);
            end
        end
    end

    // Issue one divide with start held; returns at the negedge of the DONE cycle
    task automatic issue(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expect_res);
        bit   special;
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        start    = 1'b1;
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        special  = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        e.res    = expect_res;
        e.due    = cyc + (special ? 1 : 33);
        exp_q.push_back(e);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_req) break;
            n++;
            if (n > 1) begin
                rs1_data = $urandom;
                rs2_data = $urandom;
                funct3   = 2'($urandom);
            end
        end
        check("stall_cycles", n, special ? 1 : 33);
    endtask

    task automatic idle(input int k);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (k - 1) @(posedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int t0;
        logic [1:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_valid", result_valid, 0);
        check("reset_result", result, 0);
        check("reset_stall", stall_req, 0);

        issue(2'b01, 100, 7, 14);
        idle(2);
        issue(2'b11, 100, 7, 2);
        idle(1);
        issue(2'b00, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
        issue(2'b10, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
        issue(2'b10, 7, 32'hFFFF_FFFE, 1);
        issue(2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 4);
        idle(2);
        issue(2'b01, 32'h1234_5678, 0, 32'hFFFF_FFFF);
        issue(2'b10, 32'h1234_5678, 0, 32'h1234_5678);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle(3);

        // Back-to-back with start held continuously
        p0 = pulses;
        issue(2'b01, 100, 7, 14);
        issue(2'b11, 50, 6, 2);
        idle(3);
        check("b2b_pulses", pulses - p0, 2);

        // Abort at cycle 10 of a DIVU
        p0 = pulses;
        @(posedge clk);
        #1;
        start    = 1'b1;
        funct3   = 2'b01;
        rs1_data = 100;
        rs2_data = 7;
        repeat (10) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_stall", stall_req, 0);
        check("abort_busy_before", busy, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_after", busy, 0);
        check("abort_valid", result_valid, 0);
        repeat (40) @(posedge clk);
        check("abort_no_pulse", pulses - p0, 0);

        // Reset at cycle 20 of another DIVU; result is nonzero beforehand
        @(posedge clk);
        #1;
        start    = 1'b1;
        funct3   = 2'b01;
        rs1_data = 32'hDEAD_BEEF;
        rs2_data = 3;
        repeat (20) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_stall", stall_req, 0);
        idle(2);

        for (int i = 0; i < 1000; i++) begin
            f3 = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 20);
                4: b = -$urandom_range(1, 15);
                default: ;
            endcase
            issue(f3, a, b, ref_model(f3, a, b));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(5);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the EX stage beside the single-cycle ALU/multiplier. It is the stall-request side of the pipeline hazard interface: while a divide is in flight it raises `stall_req`, and the hazard unit converts that into PC hold, IF/ID hold and an ID/EX bubble. The result is returned on a one-cycle `result_valid` pulse, aligned with the cycle in which the divide instruction leaves EX.

## Interface
- `XLEN`, 32: operand/result width. Only 32 is verified.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  EX holds a valid M-extension divide: opcode R-type, funct7 = 0000001, funct3[2] = 1. Level, not pulse; stays high while the instruction is held in EX.
- `funct3`  input  2  funct3[1:0] of the EX instruction. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `rs1_data`  input  32  dividend, forwarded EX operand.
- `rs2_data`  input  32  divisor, forwarded EX operand.
- `abort`  input  1  kill the in-flight divide, e.g. on an EX flush.
- `stall_req`  output  1  request to the hazard unit to freeze PC/IF/ID and bubble EX→MEM.
- `busy`  output  1  FSM not in IDLE.
- `result`  output  32  quotient or remainder.
- `result_valid`  output  1  one-cycle pulse; `result` is valid this cycle.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE.** When `start` is high and `abort` is low:
  - Latch the operands and the op.
  - Compute the special-case flags: `div0` (rs2 == 0) and `ovf` (signed op with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF).
  - Special case: go to DONE and preload the result.
  - Otherwise: go to BUSY with a 6-bit counter of 32.
- **BUSY.** Each cycle does one restoring step on the magnitudes:
  - rem = {rem[30:0], dvd[31]}; dvd <<= 1.
  - If rem ≥ divisor: subtract, and quotient bit = 1.
  - The counter decrements. At count 1, go to DONE.
- **DONE.** Assert `result_valid` for one cycle, then return to IDLE unconditionally.
- **Signed ops.** Operate on the absolute values.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - The final sign fix is applied when entering DONE.
- **Special results**, which override the restoring path:
  - `div0`: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - `ovf`: DIV → 0x80000000; REM → 0.
- `result` holds its value after DONE until the next operation is latched.
- `stall_req` = (IDLE & `start` & ~`abort`) | (BUSY & ~`abort`). It is 0 in DONE, so the pipeline advances on the DONE edge. The `start` level seen in the following IDLE cycle therefore belongs to the next instruction.
- `abort` has priority in every state:
  - Next state is IDLE and `result_valid` is not asserted.
  - `stall_req` is 0 in the abort cycle.
  - `result` is left unchanged.
- Back-to-back divides: DONE → IDLE → start of the new operation. There is no lost or duplicated issue.

## Timing
- Reset values: state IDLE, `stall_req` 0 (given `start` = 0), `busy` 0, `result_valid` 0, `result` 0x00000000, all internal registers 0.
- General case, with cycle 0 being the first IDLE cycle with `start`:
  - Cycles 0–32: `stall_req` = 1, i.e. 33 stall cycles.
  - Cycle 33: `result_valid` = 1, `stall_req` = 0.
- Special case (`div0`/`ovf`):
  - Cycle 0: `stall_req` = 1.
  - Cycle 1: `result_valid` = 1.
- `stall_req` is combinational from `start`/`abort` and the state. `result` and `result_valid` are registered.
- Operands are sampled only in the IDLE→BUSY/DONE cycle. Later changes on `rs1_data`/`rs2_data`/`funct3` are ignored.
- Reset mid-operation: IDLE on the next edge, outputs at their reset values, no `result_valid`.
- `start` low in BUSY has no effect, since the instruction is held by the stall. Only `abort` cancels.

## Test plan
- **DIVU.** rs1 = 100, rs2 = 7, funct3 = 01.
  - `stall_req` high for exactly 33 cycles.
  - Cycle 33: `result_valid` = 1, `result` = 14.
  - REMU with the same operands → 2.
- **Signed.** DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). REM 7 / −2 → 1. DIV −8 / −2 → 4.
- **Divide by zero.** DIVU 0x12345678 / 0 → 0xFFFFFFFF at cycle 1. REM 0x12345678 / 0 → 0x12345678. `stall_req` lasts 1 cycle.
- **Overflow.** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at cycle 1. REM → 0.
- **Abort / reset.** `abort` at cycle 10 of a DIVU:
  - Same cycle: `stall_req` 0.
  - Next cycle: IDLE, no `result_valid`.
  - `rst` at cycle 20 of another DIVU: all outputs return to reset values next cycle.
- **Back-to-back.** DIVU 100/7 then REMU 50/6 with `start` held continuously:
  - Results 14 at cycle 33 and 2 at cycle 67.
  - Exactly two `result_valid` pulses.
  - Plus 1000 random operand pairs checked against a reference model for all four ops.
